// File: rtl/four_way_mux_arbiter.sv
// Four-requester round-robin arbiter with bursts of up to MAX_BURST transfers.
// Latency: grant registered 1 cycle after req is sampled; out_valid/out_data combinational from the owner.
// Backpressure: out_ready low stalls the owner indefinitely; the owner is released after MAX_BURST transfers or when its req drops.
module four_way_mux_arbiter #(
    parameter int WIDTH     = 16,
    parameter int MAX_BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] in0,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             out_ready,
    output logic [3:0]       grant,
    output logic [1:0]       sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    typedef enum logic {IDLE, GRANT} state_t;

    localparam logic [3:0] LAST_CNT = 4'(MAX_BURST - 1);

    state_t     state, state_nxt;
    logic [3:0] grant_nxt;
    logic [1:0] sel_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       win_vld;
    logic [1:0] win_idx;
    logic [1:0] cand;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            grant <= 4'b0000;
            sel   <= 2'd0;
            ptr   <= 2'd3;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            grant <= grant_nxt;
            sel   <= sel_nxt;
            ptr   <= ptr_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Search from ptr+4 down to ptr+1 so the nearest requester after ptr wins last.
    always_comb begin
        win_vld = 1'b0;
        win_idx = 2'd0;
        cand    = ptr;
        for (int k = 4; k >= 1; k--) begin
            cand = ptr + 2'(k);
            if (req[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        sel_nxt   = sel;
        ptr_nxt   = ptr;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (win_vld) begin
                    state_nxt = GRANT;
                    grant_nxt = 4'b0001 << win_idx;
                    sel_nxt   = win_idx;
                    cnt_nxt   = 4'd0;
                end
            end
            GRANT: begin
                // A dropped request or a full burst both rotate priority past the owner.
                if (!req[sel] || (out_ready && cnt == LAST_CNT)) begin
                    state_nxt = IDLE;
                    grant_nxt = 4'b0000;
                    sel_nxt   = 2'd0;
                    ptr_nxt   = sel;
                    cnt_nxt   = 4'd0;
                end else if (out_ready) begin
                    cnt_nxt = cnt + 4'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = 4'b0000;
                sel_nxt   = 2'd0;
            end
        endcase
    end

    assign busy      = (state == GRANT);
    assign out_valid = busy && req[sel];

    always_comb begin
        out_data = '0;
        if (out_valid) begin
            case (sel)
                2'd0:    out_data = in0;
                2'd1:    out_data = in1;
                2'd2:    out_data = in2;
                default: out_data = in3;
            endcase
        end
    end

endmodule

// File: tb/tb_four_way_mux_arbiter.sv
// Directed bench for four_way_mux_arbiter: round robin, single requester, stall, early drop, mid-burst reset, random invariants.
module tb_four_way_mux_arbiter;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   req;
    logic [W-1:0] in0, in1, in2, in3;
    logic         out_ready;
    logic [3:0]   grant;
    logic [1:0]   sel;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         busy;

    int n_chk  = 0;
    int n_pass = 0;

    four_way_mux_arbiter #(.WIDTH(W), .MAX_BURST(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in0       (in0),
        .in1       (in1),
        .in2       (in2),
        .in3       (in3),
        .out_ready (out_ready),
        .grant     (grant),
        .sel       (sel),
        .out_valid (out_valid),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] dat(input int g);
        case (g)
            0:       return 16'h000A;
            1:       return 16'h000B;
            2:       return 16'h000C;
            default: return 16'h000D;
        endcase
    endfunction

    task automatic chk_grant(input string tag, input int g);
        logic [3:0] oh;
        oh = 4'b0001 << g;
        check({tag, ".grant"},     32'(grant),     32'(oh));
        check({tag, ".sel"},       32'(sel),       32'(g));
        check({tag, ".busy"},      32'(busy),      32'd1);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        check({tag, ".out_data"},  32'(out_data),  32'(dat(g)));
    endtask

    task automatic chk_idle(input string tag);
        check({tag, ".grant"},     32'(grant),     32'd0);
        check({tag, ".busy"},      32'(busy),      32'd0);
        check({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".out_data"},  32'(out_data),  32'd0);
    endtask

    task automatic do_reset();
        reset     = 1'b0;
        req       = 4'b0000;
        out_ready = 1'b1;
        #1;
        chk_idle("rst");
        check("rst.sel", 32'(sel), 32'd0);
        step();
        chk_idle("rst_hold");
        reset = 1'b1;
    endtask

    initial begin
        in0 = 16'h000A; in1 = 16'h000B; in2 = 16'h000C; in3 = 16'h000D;
        #2;
        do_reset();

        // Round robin over all four requesters, 4-cycle bursts with one idle bubble.
        req = 4'b1111;
        begin
            int order[5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    chk_grant($sformatf("rr%0d_c%0d", i, c), order[i]);
                end
                step();
                chk_idle($sformatf("rr%0d_bubble", i));
            end
        end

        // Single requester 2 is re-granted after its bubble.
        do_reset();
        req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant($sformatf("solo_c%0d", c), 2);
        end
        step();
        chk_idle("solo_bubble");
        step();
        chk_grant("solo_regrant", 2);

        // Owner 1 stalled 10 cycles, then completes exactly 4 transfers.
        do_reset();
        req       = 4'b0010;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            chk_grant($sformatf("stall_c%0d", c), 1);
        end
        out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_grant($sformatf("resume_c%0d", c), 1);
        end
        step();
        chk_idle("resume_release");

        // Owner 3 drops its request after 2 transfers; priority must move past 3.
        do_reset();
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            step();
            chk_grant($sformatf("pre0_c%0d", c), 0);
        end
        step();
        chk_idle("pre0_bubble");
        req = 4'b1000;
        for (int c = 0; c < 3; c++) begin
            step();
            chk_grant($sformatf("own3_c%0d", c), 3);
        end
        req = 4'b0011;
        #1;
        check("drop.out_valid", 32'(out_valid), 32'd0);
        check("drop.out_data",  32'(out_data),  32'd0);
        check("drop.grant",     32'(grant),     32'b1000);
        step();
        chk_idle("drop_release");
        step();
        chk_grant("drop_next", 0);

        // Reset mid-burst of owner 2.
        do_reset();
        req = 4'b1111;
        for (int g = 0; g < 2; g++) begin
            for (int c = 0; c < 4; c++) step();
            step();
        end
        step();
        step();
        chk_grant("pre_abort", 2);
        reset = 1'b0;
        #1;
        chk_idle("abort");
        check("abort.sel", 32'(sel), 32'd0);
        step();
        chk_idle("abort_hold");
        reset = 1'b1;
        step();
        chk_grant("after_abort", 0);

        // Random req/out_ready: one-hot grant, data follows the owner.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req       = 4'($urandom_range(0, 15));
            out_ready = 1'($urandom_range(0, 1));
            #1;
            check("rnd.onehot0", 32'($countones(grant) <= 1), 32'd1);
            if (out_valid) begin
                check("rnd.grant_sel", 32'(grant), 32'(4'b0001 << sel));
                check("rnd.data",      32'(out_data), 32'(dat(int'(sel))));
            end else begin
                check("rnd.data_zero", 32'(out_data), 32'd0);
            end
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
